// File: rtl/box_motion_controller_if.sv
// Control, geometry and position signals between the display generator side and the box motion controller.
interface box_motion_controller_if #(
    parameter int unsigned SPEED_W = 4
);
    logic               enable;
    logic               pause;
    logic               step;
    logic               recenter;
    logic [9:0]         xcounter;
    logic [9:0]         ycounter;
    logic [9:0]         max_x;
    logic [9:0]         max_y;
    logic [9:0]         box_width;
    logic [9:0]         box_height;
    logic [SPEED_W-1:0] speed_x;
    logic [SPEED_W-1:0] speed_y;
    logic [9:0]         box_x_pos;
    logic [9:0]         box_y_pos;
    logic               dir_x;
    logic               dir_y;
    logic               frame_tick;
    logic [7:0]         bounce_count;
    logic               busy;

    // Driver of controls/geometry, consumer of the box position
    modport master (
        output enable, pause, step, recenter, xcounter, ycounter,
               max_x, max_y, box_width, box_height, speed_x, speed_y,
        input  box_x_pos, box_y_pos, dir_x, dir_y, frame_tick, bounce_count, busy
    );

    // The motion controller itself
    modport slave (
        input  enable, pause, step, recenter, xcounter, ycounter,
               max_x, max_y, box_width, box_height, speed_x, speed_y,
        output box_x_pos, box_y_pos, dir_x, dir_y, frame_tick, bounce_count, busy
    );
endinterface

// File: rtl/box_motion_controller.sv
// Per-frame bouncing-box sequencer: advances the box once per vertical blank,
// reflects it off the screen edges and supports pause, single-step and recenter.
module box_motion_controller #(
    parameter logic [9:0]  INIT_X  = 10'd0,
    parameter logic [9:0]  INIT_Y  = 10'd0,
    parameter int unsigned SPEED_W = 4
) (
    input logic                    clk,
    input logic                    reset,
    box_motion_controller_if.slave bus
);
    localparam int unsigned POS_W = 10;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {IDLE, WAIT_FRAME, MOVE_X, MOVE_Y} state_t;

    state_t             state, state_n;
    logic [POS_W-1:0]   x_q, x_n, y_q, y_n;
    logic               dx_q, dx_n, dy_q, dy_n;
    logic [CNT_W-1:0]   bc_q, bc_n;
    logic               busy_q, busy_n;
    logic               tick_q, tick_n;
    logic               cond_q, cond_c;
    logic               sp_q, sp_n;
    logic [POS_W-1:0]   ax_pos, ay_pos;
    logic               ax_dir, ay_dir, ax_b, ay_b;

    // One axis of motion: 11-bit unsigned step with edge reflection
    function automatic void axis_step(
        input  logic [POS_W-1:0]   pos,
        input  logic               dir,
        input  logic [SPEED_W-1:0] speed,
        input  logic [POS_W-1:0]   maxv,
        input  logic [POS_W-1:0]   size,
        output logic [POS_W-1:0]   pos_n,
        output logic               dir_n,
        output logic               bounce
    );
        logic [POS_W-1:0] limit;
        logic [POS_W:0]   p, s, n;
        limit  = maxv - size;
        p      = {1'b0, pos};
        s      = 11'(speed);
        n      = p + s;
        pos_n  = pos;
        dir_n  = dir;
        bounce = 1'b0;
        if (size >= maxv) begin
            pos_n = '0;
        end else if (!dir) begin
            if (n >= {1'b0, limit}) begin
                pos_n  = limit;
                dir_n  = 1'b1;
                bounce = 1'b1;
            end else begin
                pos_n = 10'(n);
            end
        end else if (p <= s) begin
            pos_n  = '0;
            dir_n  = 1'b0;
            bounce = 1'b1;
        end else begin
            pos_n = 10'(p - s);
        end
    endfunction

    // Centred position along one axis, or 0 when the box does not fit
    function automatic logic [POS_W-1:0] center(input logic [POS_W-1:0] maxv,
                                                input logic [POS_W-1:0] size);
        if (size >= maxv) return '0;
        return 10'((maxv - size) >> 1);
    endfunction

    assign cond_c = (bus.xcounter == 10'd0) && (bus.ycounter == bus.max_y);

    // Next-state, datapath and output decode
    always_comb begin
        state_n = state;
        x_n     = x_q;
        y_n     = y_q;
        dx_n    = dx_q;
        dy_n    = dy_q;
        bc_n    = bc_q;
        sp_n    = sp_q | bus.step;
        axis_step(x_q, dx_q, bus.speed_x, bus.max_x, bus.box_width, ax_pos, ax_dir, ax_b);
        axis_step(y_q, dy_q, bus.speed_y, bus.max_y, bus.box_height, ay_pos, ay_dir, ay_b);
        case (state)
            IDLE: begin
                if (bus.enable) state_n = WAIT_FRAME;
            end
            WAIT_FRAME: begin
                if (!bus.enable) begin
                    state_n = IDLE;
                end else if (tick_q && (!bus.pause || sp_q)) begin
                    state_n = MOVE_X;
                    sp_n    = bus.step;
                end
            end
            MOVE_X: begin
                x_n     = ax_pos;
                dx_n    = ax_dir;
                if (ax_b) bc_n = bc_q + 8'd1;
                state_n = MOVE_Y;
            end
            MOVE_Y: begin
                y_n     = ay_pos;
                dy_n    = ay_dir;
                if (ay_b) bc_n = bc_q + 8'd1;
                state_n = bus.enable ? WAIT_FRAME : IDLE;
            end
            default: state_n = IDLE;
        endcase
        // Recenter overrides and aborts any update in flight
        if (bus.recenter) begin
            x_n     = center(bus.max_x, bus.box_width);
            y_n     = center(bus.max_y, bus.box_height);
            dx_n    = dx_q;
            dy_n    = dy_q;
            bc_n    = bc_q;
            state_n = bus.enable ? WAIT_FRAME : IDLE;
        end
        busy_n = (state_n == MOVE_X) || (state_n == MOVE_Y);
        tick_n = cond_c && !cond_q;
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            x_q    <= INIT_X;
            y_q    <= INIT_Y;
            dx_q   <= 1'b0;
            dy_q   <= 1'b0;
            bc_q   <= '0;
            busy_q <= 1'b0;
            tick_q <= 1'b0;
            cond_q <= 1'b0;
            sp_q   <= 1'b0;
        end else begin
            state  <= state_n;
            x_q    <= x_n;
            y_q    <= y_n;
            dx_q   <= dx_n;
            dy_q   <= dy_n;
            bc_q   <= bc_n;
            busy_q <= busy_n;
            tick_q <= tick_n;
            cond_q <= cond_c;
            sp_q   <= sp_n;
        end
    end

    assign bus.box_x_pos    = x_q;
    assign bus.box_y_pos    = y_q;
    assign bus.dir_x        = dx_q;
    assign bus.dir_y        = dy_q;
    assign bus.bounce_count = bc_q;
    assign bus.busy         = busy_q;
    assign bus.frame_tick   = tick_q;
endmodule

// File: tb/tb_box_motion_controller.sv
// Scoreboard bench for box_motion_controller: each frame update pushes the
// hand-computed position/direction/count; a monitor checks it when busy falls.
module tb_box_motion_controller;
    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       dx;
        logic       dy;
        logic [7:0] bc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];
    logic busy_prev = 1'b0;

    box_motion_controller_if #(.SPEED_W(4)) bus();

    box_motion_controller #(.INIT_X(10'd0), .INIT_Y(10'd0), .SPEED_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int x, input int y, input int dx, input int dy, input int bc);
        exp_t e;
        e.x  = 10'(x);
        e.y  = 10'(y);
        e.dx = 1'(dx);
        e.dy = 1'(dy);
        e.bc = 8'(bc);
        exp_q.push_back(e);
    endtask

    // One vertical-blank pixel followed by enough cycles for the update
    task automatic frame();
        @(negedge clk);
        bus.xcounter = 10'd0;
        bus.ycounter = bus.max_y;
        @(negedge clk);
        bus.xcounter = 10'd5;
        bus.ycounter = 10'd5;
        repeat (5) @(negedge clk);
    endtask

    task automatic do_recenter();
        @(negedge clk);
        bus.recenter = 1'b1;
        @(negedge clk);
        bus.recenter = 1'b0;
    endtask

    task automatic chk_pos(input string name, input int x, input int y);
        chk({name, "_x"}, int'(bus.box_x_pos), x);
        chk({name, "_y"}, int'(bus.box_y_pos), y);
    endtask

    // Monitor: a completed (or aborted) update is visible when busy falls
    always @(negedge clk) begin
        exp_t e;
        if (busy_prev && !bus.busy) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_update: got x=%0d y=%0d with no expected entry",
                         bus.box_x_pos, bus.box_y_pos);
            end else begin
                e = exp_q.pop_front();
                chk("upd_x", int'(bus.box_x_pos), int'(e.x));
                chk("upd_y", int'(bus.box_y_pos), int'(e.y));
                chk("upd_dir_x", int'(bus.dir_x), int'(e.dx));
                chk("upd_dir_y", int'(bus.dir_y), int'(e.dy));
                chk("upd_bounce", int'(bus.bounce_count), int'(e.bc));
            end
        end
        busy_prev = bus.busy;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ticks;
        bus.enable     = 1'b1;
        bus.pause      = 1'b0;
        bus.step       = 1'b0;
        bus.recenter   = 1'b0;
        bus.xcounter   = 10'd5;
        bus.ycounter   = 10'd5;
        bus.max_x      = 10'd640;
        bus.max_y      = 10'd480;
        bus.box_width  = 10'd40;
        bus.box_height = 10'd40;
        bus.speed_x    = 4'd4;
        bus.speed_y    = 4'd4;
        repeat (3) @(negedge clk);
        chk_pos("reset", 0, 0);
        chk("reset_dir_x", int'(bus.dir_x), 0);
        chk("reset_dir_y", int'(bus.dir_y), 0);
        chk("reset_tick", int'(bus.frame_tick), 0);
        chk("reset_bounce", int'(bus.bounce_count), 0);
        chk("reset_busy", int'(bus.busy), 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Free motion, first frame with edge-exact latency
        push(4, 4, 0, 0, 0);
        @(negedge clk);
        bus.xcounter = 10'd0;
        bus.ycounter = bus.max_y;
        @(negedge clk);
        chk("tick_high", int'(bus.frame_tick), 1);
        chk("x_hold_e0", int'(bus.box_x_pos), 0);
        bus.xcounter = 10'd5;
        bus.ycounter = 10'd5;
        @(negedge clk);
        chk("tick_low", int'(bus.frame_tick), 0);
        chk("busy_move_x", int'(bus.busy), 1);
        chk("x_hold_e1", int'(bus.box_x_pos), 0);
        @(negedge clk);
        chk("x_at_e2", int'(bus.box_x_pos), 4);
        chk("y_hold_e2", int'(bus.box_y_pos), 0);
        @(negedge clk);
        chk("y_at_e3", int'(bus.box_y_pos), 4);
        chk("busy_done", int'(bus.busy), 0);
        repeat (3) @(negedge clk);
        push(8, 8, 0, 0, 0);
        frame();
        push(12, 12, 0, 0, 0);
        frame();
        chk_pos("free3", 12, 12);

        // Recenter issued while in MOVE_X aborts the update
        push(300, 220, 0, 0, 0);
        @(negedge clk);
        bus.xcounter = 10'd0;
        bus.ycounter = bus.max_y;
        @(negedge clk);
        bus.xcounter = 10'd5;
        bus.ycounter = 10'd5;
        @(negedge clk);
        chk("busy_before_recenter", int'(bus.busy), 1);
        bus.recenter = 1'b1;
        @(negedge clk);
        bus.recenter = 1'b0;
        chk_pos("recenter_movex", 300, 220);
        chk("recenter_busy", int'(bus.busy), 0);
        repeat (4) @(negedge clk);
        chk_pos("recenter_hold", 300, 220);

        // Walk to 598, then bounce off the right edge
        bus.speed_x = 4'd15;
        bus.speed_y = 4'd0;
        for (int i = 1; i <= 19; i++) begin
            push(300 + 15 * i, 220, 0, 0, 0);
            frame();
        end
        bus.speed_x = 4'd13;
        push(598, 220, 0, 0, 0);
        frame();
        bus.speed_x = 4'd4;
        push(600, 220, 1, 0, 1);
        frame();
        chk("right_bounce_dir", int'(bus.dir_x), 1);
        push(596, 220, 1, 0, 1);
        frame();

        // Corner bounce on a 44x44 screen (limit 4, centre 2)
        bus.max_x = 10'd44;
        bus.max_y = 10'd44;
        do_recenter();
        chk_pos("small_center", 2, 2);
        chk("small_center_bounce", int'(bus.bounce_count), 1);
        bus.speed_x = 4'd0;
        bus.speed_y = 4'd2;
        push(2, 4, 1, 1, 2);
        frame();
        do_recenter();
        chk_pos("corner_setup", 2, 2);
        bus.speed_x = 4'd3;
        bus.speed_y = 4'd3;
        push(0, 0, 0, 0, 4);
        frame();
        chk("corner_bounce", int'(bus.bounce_count), 4);

        // Bounce every frame to walk the counter to 255, then wrap
        bus.speed_x = 4'd15;
        bus.speed_y = 4'd0;
        push(4, 0, 1, 0, 5);
        frame();
        bus.speed_y = 4'd15;
        for (int k = 1; k <= 125; k++) begin
            if (k % 2 == 1) push(0, 4, 0, 1, 5 + 2 * k);
            else            push(4, 0, 1, 0, 5 + 2 * k);
            frame();
        end
        chk("bounce_255", int'(bus.bounce_count), 255);
        bus.speed_y = 4'd0;
        push(4, 4, 1, 1, 0);
        frame();
        chk("bounce_wrap", int'(bus.bounce_count), 0);

        // Pause and single step
        bus.max_x   = 10'd640;
        bus.max_y   = 10'd480;
        bus.speed_x = 4'd4;
        bus.speed_y = 4'd4;
        do_recenter();
        chk_pos("pause_center", 300, 220);
        bus.pause = 1'b1;
        repeat (3) frame();
        chk_pos("paused", 300, 220);
        @(negedge clk);
        bus.step = 1'b1;
        @(negedge clk);
        bus.step = 1'b0;
        push(296, 216, 1, 1, 0);
        frame();
        frame();
        chk_pos("step_once", 296, 216);
        bus.pause = 1'b0;

        // Oversize box pins x to 0 without counting bounces
        bus.box_width = 10'd700;
        push(0, 212, 1, 1, 0);
        frame();
        push(0, 208, 1, 1, 0);
        frame();
        bus.box_width = 10'd40;

        // Counters stalled on the tick pixel give one tick
        push(0, 204, 0, 1, 1);
        ticks = 0;
        @(negedge clk);
        bus.xcounter = 10'd0;
        bus.ycounter = bus.max_y;
        repeat (5) begin
            @(negedge clk);
            if (bus.frame_tick) ticks++;
        end
        bus.xcounter = 10'd5;
        bus.ycounter = 10'd5;
        repeat (5) begin
            @(negedge clk);
            if (bus.frame_tick) ticks++;
        end
        chk("stall_single_tick", ticks, 1);
        push(4, 200, 0, 1, 1);
        frame();

        // Asynchronous reset in MOVE_X
        push(0, 0, 0, 0, 0);
        @(negedge clk);
        bus.xcounter = 10'd0;
        bus.ycounter = bus.max_y;
        @(negedge clk);
        bus.xcounter = 10'd5;
        bus.ycounter = 10'd5;
        @(negedge clk);
        chk("busy_before_reset", int'(bus.busy), 1);
        #1 reset = 1'b1;
        #1;
        chk_pos("async_reset", 0, 0);
        chk("async_reset_dir_y", int'(bus.dir_y), 0);
        chk("async_reset_bounce", int'(bus.bounce_count), 0);
        chk("async_reset_busy", int'(bus.busy), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        chk_pos("after_reset", 0, 0);
        chk("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
